// File: rtl/mem_access_ctrl_if.sv
// Requester, status and RAM-side signals of mem_access_ctrl.
// The master modport is the controller's view; slave is the environment (CPU + RAM).
interface mem_access_ctrl_if;
  logic       p0_req;
  logic       p0_rnw;
  logic [7:0] p0_addr;
  logic [7:0] p0_wdata;
  logic       p0_done;
  logic       p1_req;
  logic       p1_rnw;
  logic [7:0] p1_addr;
  logic [7:0] p1_wdata;
  logic       p1_done;
  logic [7:0] rdata;
  logic       err;
  logic       busy;
  logic [7:0] mar;
  logic [7:0] bus;
  logic       rnw;
  logic       enable;
  logic [7:0] mbr;
  logic       mfc;

  modport master (
    input  p0_req, p0_rnw, p0_addr, p0_wdata,
    input  p1_req, p1_rnw, p1_addr, p1_wdata,
    input  mbr, mfc,
    output p0_done, p1_done, rdata, err, busy,
    output mar, bus, rnw, enable
  );

  modport slave (
    output p0_req, p0_rnw, p0_addr, p0_wdata,
    output p1_req, p1_rnw, p1_addr, p1_wdata,
    output mbr, mfc,
    input  p0_done, p1_done, rdata, err, busy,
    input  mar, bus, rnw, enable
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Two-port RAM access sequencer: arbitration, enable/MFC handshake, read capture, timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module mem_access_ctrl #(
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             reset_n,
  mem_access_ctrl_if.master mif
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   mfc_sync;
  logic [7:0]             count_reg, count_next;
  logic                   timed_out_reg, timed_out_next;
  logic                   grant_reg, grant_next;
  logic [7:0]             mar_reg, mar_next;
  logic [7:0]             bus_reg, bus_next;
  logic                   rnw_reg, rnw_next;
  logic [7:0]             rdata_reg, rdata_next;
  logic                   enable_reg;
  logic                   done_int;
  logic                   req_any;
  logic                   pick;

  // mfc is asynchronous to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= mif.mfc;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign mfc_sync = sync_reg[SYNC_STAGES-1];
  assign req_any  = mif.p0_req | mif.p1_req;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_reg;

  // Pointer names the port that wins a tie; it moves to the loser of each grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg <= 1'b0;
    end else if (state_reg == IDLE && req_any) begin
      rr_ptr_reg <= ~pick;
    end
  end

  assign pick = (mif.p0_req && mif.p1_req) ? rr_ptr_reg : mif.p1_req;
`else
  assign pick = ~mif.p0_req;
`endif

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    timed_out_next = timed_out_reg;
    grant_next     = grant_reg;
    mar_next       = mar_reg;
    bus_next       = bus_reg;
    rnw_next       = rnw_reg;
    rdata_next     = rdata_reg;
    done_int       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          grant_next = pick;
          mar_next   = pick ? mif.p1_addr  : mif.p0_addr;
          bus_next   = pick ? mif.p1_wdata : mif.p0_wdata;
          rnw_next   = pick ? mif.p1_rnw   : mif.p0_rnw;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = STROBE;
      end
      STROBE: begin
        count_next = count_reg + 8'd1;
        if (mfc_sync) begin
          if (rnw_reg) begin
            rdata_next = mif.mbr;
          end
          state_next = RELEASE;
        end else if (count_reg == 8'(TIMEOUT - 1)) begin
          timed_out_next = 1'b1;
          state_next     = RELEASE;
        end
      end
      RELEASE: begin
        // A timed-out access does not wait for the RAM to drop mfc
        if (timed_out_reg || !mfc_sync) begin
          done_int       = 1'b1;
          count_next     = 8'd0;
          timed_out_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      count_reg     <= 8'd0;
      timed_out_reg <= 1'b0;
      grant_reg     <= 1'b0;
      mar_reg       <= 8'h00;
      bus_reg       <= 8'h00;
      rnw_reg       <= 1'b1;
      rdata_reg     <= 8'h00;
      enable_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      timed_out_reg <= timed_out_next;
      grant_reg     <= grant_next;
      mar_reg       <= mar_next;
      bus_reg       <= bus_next;
      rnw_reg       <= rnw_next;
      rdata_reg     <= rdata_next;
      enable_reg    <= (state_next == STROBE);
    end
  end

  assign mif.p0_done = done_int & ~grant_reg;
  assign mif.p1_done = done_int & grant_reg;
  assign mif.err     = done_int & timed_out_reg;
  assign mif.busy    = (state_reg != IDLE);
  assign mif.rdata   = rdata_reg;
  assign mif.mar     = mar_reg;
  assign mif.bus     = bus_reg;
  assign mif.rnw     = rnw_reg;
  assign mif.enable  = enable_reg;

endmodule
